qcldpc_stream_encoder: RTL and testbench

//  Streaming, multi-Z, parallelised systematic QC-LDPC encoder core. Frame = IBLKS info blocks in, IBLKS+PBLKS code blocks out.

---
 rtl/qcldpc_pkg.sv | 68 ++++++
 rtl/qcldpc_shift_rom.sv | 34 +++
 rtl/qcldpc_stream_encoder.sv | 186 ++++++++++++++++++
 tb/tb_qcldpc_stream_encoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qcldpc_pkg.sv
// Shared types, constants and helpers for the streaming QC-LDPC encoder.
package qcldpc_pkg;

  localparam int QC_NUM_Z = 3;
  localparam int QC_MAX_Z = 81;
  localparam int QC_IBLKS = 20;
  localparam int QC_PBLKS = 4;
  localparam int QC_Z_VALUES [QC_NUM_Z] = '{27, 54, 81};

  localparam int SHIFT_W = $clog2(QC_MAX_Z);
  typedef logic [SHIFT_W-1:0] shift_t;
  // All-ones entry marks a zero circulant (no contribution).
  localparam shift_t SHIFT_NONE = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, INFO = 2'd1, PARITY = 2'd2} state_t;

  typedef shift_t [QC_NUM_Z-1:0][QC_PBLKS-1:0][QC_IBLKS-1:0] shift_tab_t;

  // Lifting size for a Z index; out-of-range indices fall back to the largest Z.
  function automatic int z_of_idx(input int idx);
    if ((idx >= 0) && (idx < QC_NUM_Z)) begin
      return QC_Z_VALUES[idx];
    end else begin
      return QC_MAX_Z;
    end
  endfunction

  // Masked cyclic rotate over Z bits: out[i] = blk[(i+s) mod z] for i < z, else 0.
  function automatic logic [QC_MAX_Z-1:0] rot_z(input logic [QC_MAX_Z-1:0] blk,
                                                 input shift_t s, input int z);
    logic [QC_MAX_Z-1:0] o;
    int idx;
    o = '0;
    for (int i = 0; i < QC_MAX_Z; i++) begin
      idx  = ((i + int'(s)) >= z) ? (i + int'(s) - z) : (i + int'(s));
      o[i] = ((i < z) && (idx < QC_MAX_Z)) ? blk[idx[SHIFT_W-1:0]] : 1'b0;
    end
    return o;
  endfunction

  // Default base-matrix shifts. Column 0 of rows 0..2 is pinned (5, 3, zero circulant).
  function automatic shift_tab_t gen_shift_tab();
    shift_tab_t t;
    int zv;
    for (int z = 0; z < QC_NUM_Z; z++) begin
      zv = QC_Z_VALUES[z];
      for (int r = 0; r < QC_PBLKS; r++) begin
        for (int c = 0; c < QC_IBLKS; c++) begin
          if ((c == 0) && (r == 0)) begin
            t[z][r][c] = shift_t'(5);
          end else if ((c == 0) && (r == 1)) begin
            t[z][r][c] = shift_t'(3);
          end else if ((c == 0) && (r == 2)) begin
            t[z][r][c] = SHIFT_NONE;
          end else if ((c != 0) && (((r * 5) + c) % 6 == 5)) begin
            t[z][r][c] = SHIFT_NONE;
          end else begin
            t[z][r][c] = shift_t'(((r * 13) + (c * 7) + (z * 3) + 1) % zv);
          end
        end
      end
    end
    return t;
  endfunction

  localparam shift_tab_t S = gen_shift_tab();

endpackage

// File: rtl/qcldpc_shift_rom.sv
// Combinational shift lookup: for one beat returns the PBLKS x PLVL shifts of the selected Z.
module qcldpc_shift_rom
  import qcldpc_pkg::*;
#(
  parameter int NUM_Z = QC_NUM_Z,
  parameter int IBLKS = QC_IBLKS,
  parameter int PBLKS = QC_PBLKS,
  parameter int PLVL  = 1,
  parameter int ZW    = 2,
  parameter int CW    = 5
) (
  input  logic [ZW-1:0]              z_idx,
  input  logic [CW-1:0]              col_cnt,
  output shift_t [PBLKS*PLVL-1:0]    shifts
);

  localparam int NBEATS = IBLKS / PLVL;

  // Select the table slice matching {z_idx, col_cnt}; unmatched addresses give zero circulants.
  always_comb begin
    shifts = {(PBLKS*PLVL){SHIFT_NONE}};
    for (int zz = 0; zz < NUM_Z; zz++) begin
      for (int b = 0; b < NBEATS; b++) begin
        for (int r = 0; r < PBLKS; r++) begin
          for (int k = 0; k < PLVL; k++) begin
            shifts[r*PLVL+k] = ((z_idx == ZW'(zz)) && (col_cnt == CW'(b)))
                               ? S[zz][r][b*PLVL+k] : shifts[r*PLVL+k];
          end
        end
      end
    end
  end

endmodule

// File: rtl/qcldpc_stream_encoder.sv
// Streaming systematic QC-LDPC encoder: forwards info beats, XOR-accumulates parity, streams parity.
module qcldpc_stream_encoder
  import qcldpc_pkg::*;
#(
  parameter int NUM_Z = QC_NUM_Z,
  parameter int MAX_Z = QC_MAX_Z,
  parameter int IBLKS = QC_IBLKS,
  parameter int PBLKS = QC_PBLKS,
  parameter int PLVL  = 1
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    en_enc,
  input  logic [NUM_Z-1:0]        z_sel,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [MAX_Z*PLVL-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [MAX_Z*PLVL-1:0]   m_data,
  output logic                    m_last,
  output logic                    z_err
);

  localparam int NBEATS = IBLKS / PLVL;
  localparam int NPGRP  = PBLKS / PLVL;
  localparam int CW     = $clog2((NBEATS > 2) ? NBEATS : 2);
  localparam int PW     = $clog2((NPGRP > 2) ? NPGRP : 2);
  localparam int ZW     = $clog2((NUM_Z > 2) ? NUM_Z : 2);
  localparam logic [CW-1:0] LAST_COL = CW'(NBEATS - 1);
  localparam logic [PW-1:0] LAST_PAR = PW'(NPGRP - 1);

  if ((IBLKS % PLVL) != 0) begin : g_bad_iblks
    $fatal(1, "IBLKS must be divisible by PLVL");
  end
  if ((PBLKS % PLVL) != 0) begin : g_bad_pblks
    $fatal(1, "PBLKS must be divisible by PLVL");
  end
  if ((NUM_Z != QC_NUM_Z) || (MAX_Z != QC_MAX_Z) || (IBLKS != QC_IBLKS) || (PBLKS != QC_PBLKS)) begin : g_bad_dims
    $fatal(1, "geometry must match the shift table in qcldpc_pkg");
  end

  state_t                  state_r;
  logic [CW-1:0]           col_cnt_r;
  logic [PW-1:0]           par_cnt_r;
  logic [ZW-1:0]           z_idx_r;
  logic [MAX_Z-1:0]        acc_r [PBLKS];
  logic                    m_valid_r, m_last_r, z_err_r;
  logic [MAX_Z*PLVL-1:0]   m_data_r;

  logic                    out_free_s, z_ok_s, start_win_s, s_ready_s;
  logic                    accept_s, start_s, last_taken_s, load_par_s;
  logic [ZW-1:0]           zsel_idx_s, cur_z_s;
  int                      zval_s;
  logic [MAX_Z-1:0]        zmask_s;
  logic [MAX_Z*PLVL-1:0]   pass_s, par_grp_s;
  logic [MAX_Z-1:0]        contrib_s [PBLKS];
  shift_t [PBLKS*PLVL-1:0] shifts_s;

  qcldpc_shift_rom #(
    .NUM_Z(NUM_Z), .IBLKS(IBLKS), .PBLKS(PBLKS), .PLVL(PLVL), .ZW(ZW), .CW(CW)
  ) u_rom (
    .z_idx   (cur_z_s),
    .col_cnt (col_cnt_r),
    .shifts  (shifts_s)
  );

  // Handshake decode; a new frame may start in IDLE or as the final parity beat drains.
  always_comb begin
    out_free_s = !m_valid_r || m_ready;
    z_ok_s     = $onehot(z_sel);
    zsel_idx_s = '0;
    for (int i = 0; i < NUM_Z; i++) begin
      zsel_idx_s = z_sel[i] ? ZW'(i) : zsel_idx_s;
    end
    start_win_s = (state_r == IDLE) || ((state_r == PARITY) && m_last_r && m_valid_r);
    cur_z_s     = start_win_s ? zsel_idx_s : z_idx_r;
    zval_s      = z_of_idx(int'(cur_z_s));
    case (state_r)
      IDLE:    s_ready_s = en_enc && z_ok_s && out_free_s;
      INFO:    s_ready_s = out_free_s;
      PARITY:  s_ready_s = m_last_r && m_valid_r && m_ready && en_enc && z_ok_s;
      default: s_ready_s = 1'b0;
    endcase
    accept_s     = s_valid && s_ready_s;
    start_s      = accept_s && start_win_s;
    last_taken_s = (state_r == PARITY) && m_valid_r && m_last_r && m_ready;
    load_par_s   = (state_r == PARITY) && out_free_s && !m_last_r;
  end

  // Datapath: Z mask, systematic pass-through, rotate/XOR tree and parity group select.
  always_comb begin
    for (int i = 0; i < MAX_Z; i++) begin
      zmask_s[i] = (i < zval_s);
    end
    pass_s    = '0;
    par_grp_s = '0;
    for (int r = 0; r < PBLKS; r++) begin
      contrib_s[r] = '0;
    end
    for (int k = 0; k < PLVL; k++) begin
      pass_s[k*MAX_Z +: MAX_Z] = s_data[k*MAX_Z +: MAX_Z] & zmask_s;
      for (int r = 0; r < PBLKS; r++) begin
        contrib_s[r] = contrib_s[r] ^ ((shifts_s[r*PLVL+k] == SHIFT_NONE) ? {MAX_Z{1'b0}}
                       : rot_z(s_data[k*MAX_Z +: MAX_Z] & zmask_s, shifts_s[r*PLVL+k], zval_s));
      end
      for (int p = 0; p < NPGRP; p++) begin
        par_grp_s[k*MAX_Z +: MAX_Z] = (par_cnt_r == PW'(p)) ? acc_r[p*PLVL+k]
                                                            : par_grp_s[k*MAX_Z +: MAX_Z];
      end
    end
  end

  // FSM, counters, accumulators and the registered output stage.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      col_cnt_r <= '0;
      par_cnt_r <= '0;
      z_idx_r   <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= '0;
      z_err_r   <= 1'b0;
      for (int r = 0; r < PBLKS; r++) begin
        acc_r[r] <= '0;
      end
    end else begin
      z_err_r <= (state_r == IDLE) && s_valid && en_enc && !z_ok_s;

      if (out_free_s) begin
        if (accept_s) begin
          m_valid_r <= 1'b1;
          m_last_r  <= 1'b0;
          m_data_r  <= pass_s;
        end else if (load_par_s) begin
          m_valid_r <= 1'b1;
          m_last_r  <= (par_cnt_r == LAST_PAR);
          m_data_r  <= par_grp_s;
        end else begin
          m_valid_r <= 1'b0;
          m_last_r  <= 1'b0;
        end
      end else begin
        m_valid_r <= m_valid_r;
      end

      for (int r = 0; r < PBLKS; r++) begin
        if (accept_s) begin
          acc_r[r] <= start_s ? contrib_s[r] : (acc_r[r] ^ contrib_s[r]);
        end else begin
          acc_r[r] <= acc_r[r];
        end
      end

      if (accept_s) begin
        if (start_s) begin
          z_idx_r <= zsel_idx_s;
        end else begin
          z_idx_r <= z_idx_r;
        end
        par_cnt_r <= '0;
        if (col_cnt_r == LAST_COL) begin
          col_cnt_r <= '0;
          state_r   <= PARITY;
        end else begin
          col_cnt_r <= col_cnt_r + CW'(1);
          state_r   <= INFO;
        end
      end else if (last_taken_s) begin
        state_r <= IDLE;
      end else if (load_par_s) begin
        par_cnt_r <= (par_cnt_r == LAST_PAR) ? '0 : (par_cnt_r + PW'(1));
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign s_ready = s_ready_s;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_last  = m_last_r;
  assign z_err   = z_err_r;

endmodule

// File: tb/tb_qcldpc_stream_encoder.sv
// Directed bench for qcldpc_stream_encoder: one PLVL=1 and one PLVL=2 instance, golden parity model.
module tb_qcldpc_stream_encoder;
  import qcldpc_pkg::*;

  logic         CLK;
  logic         rst_n, en_enc, s_valid, m_ready, use2;
  logic [2:0]   z_sel;
  logic [161:0] s_data;

  logic         s_valid1, s_ready1, m_valid1, m_last1, z_err1;
  logic [80:0]  m_data1;
  logic         s_valid2, s_ready2, m_valid2, m_last2, z_err2;
  logic [161:0] m_data2;
  logic         s_ready_m, m_valid_m, m_last_m, z_err_m;
  logic [161:0] m_data_m;

  logic [80:0]  info  [20];
  logic [161:0] exp_b [24];
  logic [161:0] obs   [24];
  int           n_exp;
  int           n_chk, n_bad;

  assign s_valid1  = s_valid & ~use2;
  assign s_valid2  = s_valid & use2;
  assign s_ready_m = use2 ? s_ready2 : s_ready1;
  assign m_valid_m = use2 ? m_valid2 : m_valid1;
  assign m_last_m  = use2 ? m_last2  : m_last1;
  assign z_err_m   = use2 ? z_err2   : z_err1;
  assign m_data_m  = use2 ? m_data2  : {81'd0, m_data1};

  qcldpc_stream_encoder #(.PLVL(1)) dut1 (
    .CLK(CLK), .rst_n(rst_n), .en_enc(en_enc), .z_sel(z_sel),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data[80:0]),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .z_err(z_err1)
  );

  qcldpc_stream_encoder #(.PLVL(2)) dut2 (
    .CLK(CLK), .rst_n(rst_n), .en_enc(en_enc), .z_sel(z_sel),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2), .z_err(z_err2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [161:0] got, input logic [161:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] zmask(input int z);
    logic [80:0] m;
    m = '0;
    for (int i = 0; i < 81; i++) m[i] = (i < z);
    return m;
  endfunction

  // Reference rotate: right-rotate a doubled copy of the Z-bit block.
  function automatic logic [80:0] grot(input logic [80:0] x, input int s, input int z);
    logic [161:0] xx;
    xx = {81'd0, x & zmask(z)};
    xx = xx | (xx << z);
    return 81'(xx >> s) & zmask(z);
  endfunction

  task automatic build_exp(input int zi, input int plv);
    logic [80:0] par [4];
    logic [80:0] m;
    shift_t      sh;
    int          z, nb;
    z  = QC_Z_VALUES[zi];
    m  = zmask(z);
    nb = 20 / plv;
    for (int r = 0; r < 4; r++) begin
      par[r] = '0;
      for (int c = 0; c < 20; c++) begin
        sh = S[zi[1:0]][r[1:0]][c[4:0]];
        if (sh != SHIFT_NONE) par[r] = par[r] ^ grot(info[c], int'(sh), z);
      end
    end
    for (int b = 0; b < 24; b++) exp_b[b] = '0;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < plv; k++) exp_b[b][k*81 +: 81] = info[b*plv+k] & m;
    for (int g = 0; g < 4 / plv; g++)
      for (int k = 0; k < plv; k++) exp_b[nb+g][k*81 +: 81] = par[g*plv+k];
    n_exp = nb + 4 / plv;
  endtask

  function automatic logic [161:0] pack_beat(input int beat, input int plv);
    logic [161:0] d;
    d = '0;
    for (int k = 0; k < plv; k++) d[k*81 +: 81] = info[beat*plv+k];
    return d;
  endfunction

  // Drive one frame and score every output beat against the model.
  task automatic run_frame(input int zi, input int plv, input bit rnd, input string tag);
    int nb, beat, got, cyc;
    build_exp(zi, plv);
    nb = 20 / plv;
    use2 = (plv == 2);
    z_sel = 3'(1 << zi);
    en_enc = 1'b1;
    beat = 0; got = 0; cyc = 0;
    while ((got < n_exp) && (cyc < 2000)) begin
      @(negedge CLK);
      m_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
      if (rnd && (beat > 0)) begin
        z_sel  = 3'b001;
        en_enc = 1'b0;
      end
      if (beat < nb) begin
        s_valid = 1'b1;
        s_data  = pack_beat(beat, plv);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (s_valid && s_ready_m) beat++;
      if (m_valid_m && m_ready) begin
        obs[got] = m_data_m;
        check($sformatf("%s data%0d", tag, got), m_data_m, exp_b[got]);
        check($sformatf("%s last%0d", tag, got), 162'(m_last_m), 162'(got == n_exp - 1));
        got++;
      end
      cyc++;
    end
    check($sformatf("%s beats", tag), 162'(got), 162'(n_exp));
    @(negedge CLK);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1 check($sformatf("%s no_extra", tag), 162'(m_valid_m), 162'd0);
  endtask

  initial begin
    int beat;
    n_chk = 0; n_bad = 0;
    rst_n = 1'b0; en_enc = 1'b0; s_valid = 1'b0; m_ready = 1'b1; use2 = 1'b0;
    z_sel = 3'b001; s_data = '0;
    for (int c = 0; c < 20; c++) info[c] = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check("rst m_valid1", 162'(m_valid1), 162'd0);
    check("rst m_last1",  162'(m_last1),  162'd0);
    check("rst z_err1",   162'(z_err1),   162'd0);
    check("rst s_ready1", 162'(s_ready1), 162'd0);
    check("rst m_valid2", 162'(m_valid2), 162'd0);
    @(negedge CLK) rst_n = 1'b1;

    // 1: all-zero frame at Z=81
    run_frame(2, 1, 1'b0, "t1");

    // 2: Z=27, blk0 bit0 -> parity0 bit22
    info[0] = 81'd1;
    run_frame(0, 1, 1'b0, "t2");
    check("t2 par0", obs[20], 162'd1 << 22);
    check("t2 par1", obs[21], 162'd1 << 24);
    check("t2 par2", obs[22], 162'd0);
    check("t2 par3", obs[23], 162'd1 << 14);
    for (int i = 0; i < 24; i++) check($sformatf("t2 hibits%0d", i), obs[i] >> 27, 162'd0);

    // 3: Z=27, blk0 bit1 -> parity1 bit25, parity2 zero circulant
    info[0] = 81'd2;
    run_frame(0, 1, 1'b1, "t3");
    check("t3 info0", obs[0],  162'd2);
    check("t3 par0",  obs[20], 162'd1 << 23);
    check("t3 par1",  obs[21], 162'd1 << 25);
    check("t3 par2",  obs[22], 162'd0);
    check("t3 par3",  obs[23], 162'd1 << 15);

    // 4: random frames, PLVL=2, Z=54, random back-pressure
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 20; c++) info[c] = 81'({$urandom, $urandom, $urandom});
      run_frame(1, 2, 1'b1, $sformatf("t4f%0d", f));
    end

    // 5: non-one-hot z_sel -> z_err pulse, no accept
    @(negedge CLK);
    use2 = 1'b0; en_enc = 1'b1; z_sel = 3'b011; s_valid = 1'b1; s_data = 162'd5;
    #1 check("t5 s_ready", 162'(s_ready_m), 162'd0);
    @(negedge CLK);
    s_valid = 1'b0;
    #1;
    check("t5 z_err", 162'(z_err_m), 162'd1);
    check("t5 m_valid", 162'(m_valid_m), 162'd0);
    @(negedge CLK);
    #1 check("t5 z_err_end", 162'(z_err_m), 162'd0);
    for (int c = 0; c < 20; c++) info[c] = 81'({$urandom, $urandom, $urandom});
    run_frame(2, 1, 1'b0, "t5");

    // 6: async reset after 7 info beats, then a clean frame
    for (int c = 0; c < 20; c++) info[c] = 81'({$urandom, $urandom, $urandom});
    use2 = 1'b0; z_sel = 3'b001; en_enc = 1'b1; m_ready = 1'b1;
    beat = 0;
    for (int cyc = 0; (cyc < 100) && (beat < 7); cyc++) begin
      @(negedge CLK);
      s_valid = 1'b1;
      s_data  = pack_beat(beat, 1);
      #1;
      if (s_ready_m) beat++;
    end
    @(negedge CLK);
    s_valid = 1'b0;
    #1 check("t6 pre m_valid", 162'(m_valid_m), 162'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst m_valid", 162'(m_valid_m), 162'd0);
    check("t6 rst m_last",  162'(m_last_m),  162'd0);
    @(negedge CLK) rst_n = 1'b1;
    for (int c = 0; c < 20; c++) info[c] = 81'({$urandom, $urandom, $urandom});
    run_frame(0, 1, 1'b0, "t6");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
